// File: rtl/timer_preset_sequencer.sv
// timer_preset_sequencer
//
// Purpose: sits between the four button edge-to-pulse generators and the
// countdown timer (1.024 kHz domain). It forwards single user button pulses
// to the timer and, on a preset load, plays a sequence of one-cycle pulses
// into the timer's control inputs:
//   stop, un-expire, clear, +1 min (repeated), +15 s (repeated), [start].
// It also tracks whether the timer is counting, so that it knows whether the
// sequence has to stop the timer first.
//
// Build option: define PRESET_AUTOSTART_EN to append a START step, so the
// timer begins counting as soon as the preset has been loaded. Without it,
// the timer is left idle showing the preset time.
//
// Ports:
//   clk               clock, 1.024 kHz
//   reset             asynchronous, active-low
//   i_preset_sel      preset index, sampled with i_preset_load
//   i_preset_load     one-cycle preset load request
//   i_btn_startstop   user pulse
//   i_btn_reset       user pulse (also aborts a running preset sequence)
//   i_btn_incmin      user pulse
//   i_btn_incsec      user pulse
//   i_alarm_enable    timer alarm output, 1 = timer expired
//   o_ctrl_startstop  registered pulse to timer
//   o_ctrl_reset      registered pulse to timer
//   o_ctrl_incmin     registered pulse to timer
//   o_ctrl_incsec     registered pulse to timer
//   o_busy            preset sequence in progress
//   o_running         tracked timer counting state
module timer_preset_sequencer #(
  parameter int PRESET_MIN_0 = 3,
  parameter int PRESET_MIN_1 = 5,
  parameter int PRESET_MIN_2 = 2,
  parameter int PRESET_MIN_3 = 10,
  parameter int PRESET_Q_0   = 0,
  parameter int PRESET_Q_1   = 0,
  parameter int PRESET_Q_2   = 2,
  parameter int PRESET_Q_3   = 0,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_preset_sel,
  input  logic       i_preset_load,
  input  logic       i_btn_startstop,
  input  logic       i_btn_reset,
  input  logic       i_btn_incmin,
  input  logic       i_btn_incsec,
  input  logic       i_alarm_enable,
  output logic       o_ctrl_startstop,
  output logic       o_ctrl_reset,
  output logic       o_ctrl_incmin,
  output logic       o_ctrl_incsec,
  output logic       o_busy,
  output logic       o_running
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  // The state names the step whose pulse was issued most recently; the
  // step's gap cycles are spent in that same state.
  typedef enum logic [2:0] {
    S_IDLE,
    S_STOP,
    S_UNEXPIRE,
    S_CLEAR,
    S_INCMIN,
    S_INCSEC,
    S_START
  } state_t;

  state_t        r_state, w_nextState, w_enterStep, w_tailStep;
  state_t        w_afterClear, w_afterSec;
  logic          w_doEnter;
  logic [6:0]    r_minCnt, w_minCntNext, w_selMin;
  logic [1:0]    r_qCnt, w_qCntNext, w_selQ;
  logic [GW-1:0] r_gapCnt, w_gapCntNext;
  logic          w_issueSs, w_issueRst, w_issueMin, w_issueSec;
  logic          r_running, w_runningNext;

  // Step that follows the last +15 s pulse.
`ifdef PRESET_AUTOSTART_EN
  assign w_tailStep = S_START;
`else
  assign w_tailStep = S_IDLE;
`endif

  // The counters hold the pulses still to be issued, so a zero count skips
  // the step entirely.
  assign w_afterClear = (r_minCnt != 7'd0) ? S_INCMIN :
                        (r_qCnt != 2'd0)   ? S_INCSEC : w_tailStep;
  assign w_afterSec   = (r_qCnt != 2'd0)   ? S_INCSEC : w_tailStep;

  always_comb begin
    w_selMin = 7'(PRESET_MIN_0);
    w_selQ   = 2'(PRESET_Q_0);
    case (i_preset_sel)
      2'd1: begin w_selMin = 7'(PRESET_MIN_1); w_selQ = 2'(PRESET_Q_1); end
      2'd2: begin w_selMin = 7'(PRESET_MIN_2); w_selQ = 2'(PRESET_Q_2); end
      2'd3: begin w_selMin = 7'(PRESET_MIN_3); w_selQ = 2'(PRESET_Q_3); end
      default: ;
    endcase
  end

  // Next-state logic. Entering a step always issues that step's pulse and
  // reloads the gap counter; entering IDLE issues nothing.
  always_comb begin
    w_nextState  = r_state;
    w_minCntNext = r_minCnt;
    w_qCntNext   = r_qCnt;
    w_gapCntNext = r_gapCnt;
    w_doEnter    = 1'b0;
    w_enterStep  = S_IDLE;
    w_issueSs    = 1'b0;
    w_issueRst   = 1'b0;
    w_issueMin   = 1'b0;
    w_issueSec   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_preset_load) begin
          w_minCntNext = w_selMin;
          w_qCntNext   = w_selQ;
          w_doEnter    = 1'b1;
          if (r_running)           w_enterStep = S_STOP;
          else if (i_alarm_enable) w_enterStep = S_UNEXPIRE;
          else                     w_enterStep = S_CLEAR;
        end else if (i_btn_startstop) begin
          w_issueSs = 1'b1;
        end else if (i_btn_reset) begin
          w_issueRst = 1'b1;
        end else if (i_btn_incmin) begin
          w_issueMin = 1'b1;
        end else if (i_btn_incsec) begin
          w_issueSec = 1'b1;
        end
      end
      default: begin
        // A user reset aborts the sequence and replaces whatever pulse was due.
        if (i_btn_reset) begin
          w_nextState  = S_IDLE;
          w_issueRst   = 1'b1;
          w_gapCntNext = '0;
          w_minCntNext = 7'd0;
          w_qCntNext   = 2'd0;
        end else if (r_gapCnt != '0) begin
          w_gapCntNext = r_gapCnt - GW'(1);
        end else begin
          w_doEnter = 1'b1;
          case (r_state)
            S_STOP:           w_enterStep = i_alarm_enable ? S_UNEXPIRE : S_CLEAR;
            S_UNEXPIRE:       w_enterStep = S_CLEAR;
            S_CLEAR, S_INCMIN: w_enterStep = w_afterClear;
            S_INCSEC:         w_enterStep = w_afterSec;
            default:          w_enterStep = S_IDLE;
          endcase
        end
      end
    endcase

    if (w_doEnter) begin
      w_nextState  = w_enterStep;
      w_gapCntNext = GAP_LOAD;
      case (w_enterStep)
        S_STOP, S_START:     w_issueSs  = 1'b1;
        S_UNEXPIRE, S_CLEAR: w_issueRst = 1'b1;
        S_INCMIN: begin
          w_issueMin   = 1'b1;
          w_minCntNext = r_minCnt - 7'd1;
        end
        S_INCSEC: begin
          w_issueSec = 1'b1;
          w_qCntNext = r_qCnt - 2'd1;
        end
        default: w_gapCntNext = '0;
      endcase
    end
  end

  // The running model updates on the same edge that issues the pulse, so a
  // preset load always sees the run state including the latest pulse.
  always_comb begin
    w_runningNext = r_running;
    if (i_alarm_enable)  w_runningNext = 1'b0;
    else if (w_issueRst) w_runningNext = 1'b0;
    else if (w_issueSs)  w_runningNext = ~r_running;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_minCnt         <= 7'd0;
      r_qCnt           <= 2'd0;
      r_gapCnt         <= '0;
      r_running        <= 1'b0;
      o_ctrl_startstop <= 1'b0;
      o_ctrl_reset     <= 1'b0;
      o_ctrl_incmin    <= 1'b0;
      o_ctrl_incsec    <= 1'b0;
    end else begin
      r_state          <= w_nextState;
      r_minCnt         <= w_minCntNext;
      r_qCnt           <= w_qCntNext;
      r_gapCnt         <= w_gapCntNext;
      r_running        <= w_runningNext;
      o_ctrl_startstop <= w_issueSs;
      o_ctrl_reset     <= w_issueRst;
      o_ctrl_incmin    <= w_issueMin;
      o_ctrl_incsec    <= w_issueSec;
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_running = r_running;

endmodule

// File: tb/tb_timer_preset_sequencer.sv
// tb_timer_preset_sequencer
//
// Purpose: self-checking bench for timer_preset_sequencer. Stimulus tasks
// push the expected ctrl pulses (cycle and kind) into a scoreboard queue,
// worked out from the preset rules; a monitor pops and compares every pulse
// the DUT produces and checks the busy window each cycle.
//
// Build option: PRESET_AUTOSTART_EN selects the auto-start expectation.
module tb_timer_preset_sequencer;

  localparam int GAP  = 1;
  localparam int STEP = 1 + GAP;
`ifdef PRESET_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Pulse kinds as {startstop, reset, incmin, incsec}.
  localparam logic [3:0] K_SS  = 4'b1000;
  localparam logic [3:0] K_RST = 4'b0100;
  localparam logic [3:0] K_MIN = 4'b0010;
  localparam logic [3:0] K_SEC = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } exp_t;

  exp_t expQ[$];
  int   presetMin[4] = '{3, 5, 2, 10};
  int   presetQ[4]   = '{0, 0, 2, 0};

  logic       clk;
  logic       reset;
  logic [1:0] i_preset_sel;
  logic       i_preset_load;
  logic       i_btn_startstop;
  logic       i_btn_reset;
  logic       i_btn_incmin;
  logic       i_btn_incsec;
  logic       i_alarm_enable;
  logic       o_ctrl_startstop;
  logic       o_ctrl_reset;
  logic       o_ctrl_incmin;
  logic       o_ctrl_incsec;
  logic       o_busy;
  logic       o_running;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  bit monEn  = 1'b0;

  // Reference state of the timer as seen by the sequencer.
  bit mRunning = 1'b0;
  bit mAlarm   = 1'b0;
  int busyFrom = 1;
  int busyTo   = 0;

  timer_preset_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_preset_sel     (i_preset_sel),
    .i_preset_load    (i_preset_load),
    .i_btn_startstop  (i_btn_startstop),
    .i_btn_reset      (i_btn_reset),
    .i_btn_incmin     (i_btn_incmin),
    .i_btn_incsec     (i_btn_incsec),
    .i_alarm_enable   (i_alarm_enable),
    .o_ctrl_startstop (o_ctrl_startstop),
    .o_ctrl_reset     (o_ctrl_reset),
    .o_ctrl_incmin    (o_ctrl_incmin),
    .o_ctrl_incsec    (o_ctrl_incsec),
    .o_busy           (o_busy),
    .o_running        (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every observed pulse against the scoreboard head and
  // checks busy against the expected window.
  always @(negedge clk) begin
    logic [3:0] seen;
    exp_t       e;
    bit         expBusy;
    if (monEn) begin
      seen = {o_ctrl_startstop, o_ctrl_reset, o_ctrl_incmin, o_ctrl_incsec};
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        nTests++;
        nFail++;
        $display("[TB] FAIL missedPulse at cyc %0d: got nothing, required kind %b at cyc %0d", cyc, e.kind, e.cyc);
      end
      if (seen != 4'b0000) begin
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpectedPulse at cyc %0d: got kind %b, required none", cyc, seen);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cyc || e.kind != seen) begin
            nFail++;
            $display("[TB] FAIL pulse: got kind %b at cyc %0d, required kind %b at cyc %0d", seen, cyc, e.kind, e.cyc);
          end
        end
      end
      expBusy = (cyc >= busyFrom) && (cyc <= busyTo);
      nTests++;
      if (o_busy !== expBusy) begin
        nFail++;
        $display("[TB] FAIL busy at cyc %0d: got %b, required %b", cyc, o_busy, expBusy);
      end
    end
  end

  function automatic void pushExp(input int c, input logic [3:0] k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    expQ.push_back(e);
  endfunction

  // Reference model: reaction to the inputs driven in cycle t.
  function automatic void modelStep(input int t, input logic load, input logic [1:0] sel,
                                    input logic [3:0] btn);
    logic [3:0] ks[$];
    logic [3:0] kind;
    if (t <= busyTo) begin
      if (btn[2]) begin
        while (expQ.size() > 0 && expQ[expQ.size()-1].cyc > t) void'(expQ.pop_back());
        pushExp(t + 1, K_RST);
        busyTo   = t;
        mRunning = 1'b0;
      end
    end else if (load) begin
      if (mRunning && !mAlarm) ks.push_back(K_SS);
      if (mAlarm) ks.push_back(K_RST);
      ks.push_back(K_RST);
      repeat (presetMin[sel]) ks.push_back(K_MIN);
      repeat (presetQ[sel]) ks.push_back(K_SEC);
      if (AUTO) ks.push_back(K_SS);
      foreach (ks[i]) pushExp(t + 1 + i * STEP, ks[i]);
      busyFrom = t + 1;
      busyTo   = t + STEP * ks.size();
      mRunning = AUTO && !mAlarm;
    end else if (btn != 4'b0000) begin
      kind = btn[3] ? K_SS : btn[2] ? K_RST : btn[1] ? K_MIN : K_SEC;
      pushExp(t + 1, kind);
      if (mAlarm)              mRunning = 1'b0;
      else if (kind == K_SS)   mRunning = !mRunning;
      else if (kind == K_RST)  mRunning = 1'b0;
    end
  endfunction

  // Drives one cycle of inputs (entered and left at #1 after a rising edge).
  task automatic applyStimulus(input logic load, input logic [1:0] sel, input logic [3:0] btn);
    int t;
    t = cyc;
    i_preset_load   = load;
    i_preset_sel    = sel;
    {i_btn_startstop, i_btn_reset, i_btn_incmin, i_btn_incsec} = btn;
    modelStep(t, load, sel, btn);
    @(posedge clk); #1;
    i_preset_load   = 1'b0;
    {i_btn_startstop, i_btn_reset, i_btn_incmin, i_btn_incsec} = 4'b0000;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setAlarm(input bit a);
    i_alarm_enable = a;
    mAlarm = a;
    if (a) mRunning = 1'b0;
    idleCycles(2);
  endtask

  // End-of-transaction check: nothing left in the scoreboard, running matches.
  task automatic checkOutput(input string name);
    idleCycles(2);
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL %s pending: got %0d outstanding pulses, required 0", name, expQ.size());
      expQ.delete();
    end
    nTests++;
    if (o_running !== mRunning) begin
      nFail++;
      $display("[TB] FAIL %s running: got %b, required %b", name, o_running, mRunning);
    end
  endtask

  // Preset load, optional btn_reset abort at offset abortOff after the load
  // cycle, optional ignored junk pulses while busy.
  task automatic runLoad(input string name, input logic [1:0] sel, input logic [3:0] btnAtLoad,
                         input int abortOff, input bit junk);
    int k;
    applyStimulus(1'b1, sel, btnAtLoad);
    k = 1;
    while (cyc <= busyTo && k < 1000) begin
      if (k == abortOff) applyStimulus(1'b0, 2'd0, K_RST);
      else if (junk && $urandom_range(0, 2) == 0)
        applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      {1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3))});
      else idleCycles(1);
      k++;
    end
    checkOutput(name);
  endtask

  initial begin
    #500000;
    nTests++;
    nFail++;
    $display("[TB] FAIL timeout: got no completion, required finish before time limit");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    reset = 1'b0;
    i_preset_sel = 2'd0;
    i_preset_load = 1'b0;
    {i_btn_startstop, i_btn_reset, i_btn_incmin, i_btn_incsec} = 4'b0000;
    i_alarm_enable = 1'b0;

    // Reset held: every input pulsed, all outputs must stay low.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      i_preset_load = 1'b1;
      i_preset_sel  = 2'($urandom_range(0, 3));
      {i_btn_startstop, i_btn_reset, i_btn_incmin, i_btn_incsec} = 4'($urandom_range(1, 15));
      i_alarm_enable = 1'($urandom_range(0, 1));
      @(negedge clk);
      nTests++;
      if ({o_ctrl_startstop, o_ctrl_reset, o_ctrl_incmin, o_ctrl_incsec, o_busy, o_running} !== 6'b0) begin
        nFail++;
        $display("[TB] FAIL resetState: got %b, required 000000",
                 {o_ctrl_startstop, o_ctrl_reset, o_ctrl_incmin, o_ctrl_incsec, o_busy, o_running});
      end
    end
    @(posedge clk); #1;
    i_preset_load = 1'b0;
    {i_btn_startstop, i_btn_reset, i_btn_incmin, i_btn_incsec} = 4'b0000;
    i_alarm_enable = 1'b0;
    reset = 1'b1;
    monEn = 1'b1;
    idleCycles(2);

    runLoad("idleLoad2m30", 2'd2, 4'b0000, 0, 1'b0);
    applyStimulus(1'b0, 2'd0, K_SS | K_MIN);
    checkOutput("idleStartstopIncmin");
    runLoad("runningLoad3m", 2'd0, 4'b0000, 0, 1'b0);
    setAlarm(1'b1);
    runLoad("expiredLoad10m", 2'd3, 4'b0000, 0, 1'b0);
    setAlarm(1'b0);
    runLoad("abortIncmin4", 2'd3, 4'b0000, 9, 1'b0);
    runLoad("loadBeatsButtons", 2'd1, 4'b1111, 0, 1'b0);
    applyStimulus(1'b0, 2'd0, K_RST | K_SEC);
    checkOutput("idleResetIncsec");
    applyStimulus(1'b0, 2'd0, K_SEC);
    checkOutput("idleIncsec");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: setAlarm(1'($urandom_range(0, 1)));
        1: begin
          applyStimulus(1'b0, 2'd0, 4'($urandom_range(1, 15)));
          checkOutput("randomButton");
        end
        default: runLoad("randomLoad", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0, 1'b1);
      endcase
    end

    idleCycles(3);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
